rca_seq_ctrl: RTL

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

---
 rtl/nc_pkg.sv | 22 ++
 rtl/rca_addr_gen.sv | 66 ++++++
 rtl/rca_seq_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/nc_pkg.sv
// Shared definitions for the ripple-carry-add sequencer: FSM state encoding,
// default widths, operand length limit and write-back source encodings.
package nc_pkg;

    localparam int ADDR_W   = 8;   // wordline row-address width
    localparam int NB_W     = 5;   // operand bit-count width
    localparam int MAX_BITS = 16;  // longest legal operand

    // Write-back source select
    localparam logic WR_SEL_SUM   = 1'b0;
    localparam logic WR_SEL_CARRY = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ACT   = 3'd2,
        S_WB    = 3'd3,
        S_CARRY = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/rca_addr_gen.sv
// Bit-index counter and row-address adders for the bit-serial in-memory add.
// Rows are produced for the index the counter will hold next cycle, so the
// controller can register them together with its next-state strobes.
module rca_addr_gen #(
    parameter int ADDR_W = nc_pkg::ADDR_W,
    parameter int NB_W   = nc_pkg::NB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,     // accept new operation: capture bases, clear index
    input  logic              inc,      // advance to the next bit
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] d_base,
    input  logic [NB_W-1:0]   nbits,
    output logic              i_last,   // current index is the operand MSB
    output logic [ADDR_W-1:0] a_row,
    output logic [ADDR_W-1:0] b_row,
    output logic [ADDR_W-1:0] d_row
);

    logic [NB_W-1:0]   r_i;
    logic [NB_W-1:0]   r_nbits;
    logic [ADDR_W-1:0] r_a_base;
    logic [ADDR_W-1:0] r_b_base;
    logic [ADDR_W-1:0] r_d_base;
    logic [NB_W-1:0]   w_i_nxt;

    // Next index: cleared on load, bumped after every write-back. The bump
    // after the last bit leaves i = nbits, which makes d_row the carry row.
    always_comb begin
        w_i_nxt = r_i;
        if (load)
            w_i_nxt = '0;
        else if (inc)
            w_i_nxt = r_i + NB_W'(1);
    end

    // Index counter and registered operand geometry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i      <= '0;
            r_nbits  <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_d_base <= '0;
        end else begin
            r_i <= w_i_nxt;
            if (load) begin
                r_nbits  <= nbits;
                r_a_base <= a_base;
                r_b_base <= b_base;
                r_d_base <= d_base;
            end
        end
    end

    // Row adders wrap modulo 2^ADDR_W by construction
    always_comb begin
        i_last = (r_i == (r_nbits - NB_W'(1)));
        a_row  = r_a_base + ADDR_W'(w_i_nxt);
        b_row  = r_b_base + ADDR_W'(w_i_nxt);
        d_row  = r_d_base + ADDR_W'(w_i_nxt);
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequencer for a bit-serial ripple-carry add inside a memory array.
// Per bit: ACT fires the A/B wordlines and sense amps, WB writes SUM to the
// destination row and latches COUT; a final CARRY cycle writes the carry-out.
// All outputs are flops loaded from the next-state decode.
module rca_seq_ctrl #(
    parameter int ADDR_W = nc_pkg::ADDR_W,
    parameter int NB_W   = nc_pkg::NB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cin,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] d_base,
    input  logic [NB_W-1:0]   nbits,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wl_en,
    output logic [ADDR_W-1:0] wl_a_addr,
    output logic [ADDR_W-1:0] wl_b_addr,
    output logic              sa_en,
    output logic              carry_init,
    output logic              carry_val,
    output logic              carry_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_sel
);

    nc_pkg::state_e    r_state;
    nc_pkg::state_e    w_state_nxt;

    logic              w_len_ok;
    logic              w_load;
    logic              w_inc;
    logic              w_err_nxt;
    logic              w_i_last;
    logic [ADDR_W-1:0] w_a_row;
    logic [ADDR_W-1:0] w_b_row;
    logic [ADDR_W-1:0] w_d_row;

    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_wl_en_nxt;
    logic [ADDR_W-1:0] w_wl_a_nxt;
    logic [ADDR_W-1:0] w_wl_b_nxt;
    logic              w_sa_en_nxt;
    logic              w_cinit_nxt;
    logic              w_cval_nxt;
    logic              w_cen_nxt;
    logic              w_wr_en_nxt;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic              w_wr_sel_nxt;

    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_wl_en;
    logic [ADDR_W-1:0] r_wl_a;
    logic [ADDR_W-1:0] r_wl_b;
    logic              r_sa_en;
    logic              r_cinit;
    logic              r_cval;
    logic              r_cen;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_sel;

    rca_addr_gen #(
        .ADDR_W (ADDR_W),
        .NB_W   (NB_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .inc    (w_inc),
        .a_base (a_base),
        .b_base (b_base),
        .d_base (d_base),
        .nbits  (nbits),
        .i_last (w_i_last),
        .a_row  (w_a_row),
        .b_row  (w_b_row),
        .d_row  (w_d_row)
    );

    // Operand length must be 1..MAX_BITS to be accepted
    always_comb begin
        w_len_ok = (nbits != '0) && (int'(nbits) <= nc_pkg::MAX_BITS);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= nc_pkg::S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            nc_pkg::S_IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_state_nxt = nc_pkg::S_LOAD;
                        w_load      = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            nc_pkg::S_LOAD:  w_state_nxt = nc_pkg::S_ACT;
            nc_pkg::S_ACT:   w_state_nxt = nc_pkg::S_WB;
            nc_pkg::S_WB: begin
                w_inc       = 1'b1;
                w_state_nxt = w_i_last ? nc_pkg::S_CARRY : nc_pkg::S_ACT;
            end
            nc_pkg::S_CARRY: w_state_nxt = nc_pkg::S_DONE;
            nc_pkg::S_DONE:  w_state_nxt = nc_pkg::S_IDLE;
            default:         w_state_nxt = nc_pkg::S_IDLE;
        endcase
    end

    // Output decode for the state being entered; idle values are all zero
    always_comb begin
        w_busy_nxt    = (w_state_nxt != nc_pkg::S_IDLE);
        w_done_nxt    = 1'b0;
        w_wl_en_nxt   = 1'b0;
        w_wl_a_nxt    = '0;
        w_wl_b_nxt    = '0;
        w_sa_en_nxt   = 1'b0;
        w_cinit_nxt   = 1'b0;
        w_cval_nxt    = 1'b0;
        w_cen_nxt     = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = '0;
        w_wr_sel_nxt  = nc_pkg::WR_SEL_SUM;
        case (w_state_nxt)
            nc_pkg::S_LOAD: begin
                // Entered only from an accepted start, so cin is the sampled carry-in
                w_cinit_nxt = 1'b1;
                w_cval_nxt  = cin;
            end
            nc_pkg::S_ACT: begin
                w_wl_en_nxt = 1'b1;
                w_sa_en_nxt = 1'b1;
                w_wl_a_nxt  = w_a_row;
                w_wl_b_nxt  = w_b_row;
            end
            nc_pkg::S_WB: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_sel_nxt  = nc_pkg::WR_SEL_SUM;
                w_wr_addr_nxt = w_d_row;
                w_cen_nxt     = 1'b1;
            end
            nc_pkg::S_CARRY: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_sel_nxt  = nc_pkg::WR_SEL_CARRY;
                w_wr_addr_nxt = w_d_row;
            end
            nc_pkg::S_DONE: w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wl_en   <= 1'b0;
            r_wl_a    <= '0;
            r_wl_b    <= '0;
            r_sa_en   <= 1'b0;
            r_cinit   <= 1'b0;
            r_cval    <= 1'b0;
            r_cen     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_sel  <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_wl_en   <= w_wl_en_nxt;
            r_wl_a    <= w_wl_a_nxt;
            r_wl_b    <= w_wl_b_nxt;
            r_sa_en   <= w_sa_en_nxt;
            r_cinit   <= w_cinit_nxt;
            r_cval    <= w_cval_nxt;
            r_cen     <= w_cen_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_sel  <= w_wr_sel_nxt;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign wl_en      = r_wl_en;
    assign wl_a_addr  = r_wl_a;
    assign wl_b_addr  = r_wl_b;
    assign sa_en      = r_sa_en;
    assign carry_init = r_cinit;
    assign carry_val  = r_cval;
    assign carry_en   = r_cen;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_sel     = r_wr_sel;

endmodule
